// File: rtl/cachebus_arbiter_pkg.sv
// Shared types for the cachebus arbiter slice: bus word, FSM states and grant select.
// The starve counter width helper keeps a 3-bit floor regardless of the limit.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } arb_gnt_e;

    function automatic int starve_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/cachebus_arbiter_if.sv
// Requester and downstream cachebus signals shared by the arbiter and its environment.
// The arbiter takes the slave view; whatever drives requests and responses uses master.
interface cachebus_arbiter_if;
    import rvga_types::*;

    rvga_word i_addr_i;
    logic     i_read_i;
    rvga_word i_rdata_o;
    logic     i_resp_o;

    rvga_word d_addr_i;
    logic     d_read_i;
    logic     d_write_i;
    rvga_word d_wdata_i;
    rvga_word d_rdata_o;
    logic     d_resp_o;

    rvga_word m_addr_o;
    rvga_word m_wdata_o;
    logic     m_read_o;
    logic     m_write_o;
    rvga_word m_rdata_i;
    logic     m_resp_i;

    modport slave (
        input  i_addr_i, i_read_i,
        output i_rdata_o, i_resp_o,
        input  d_addr_i, d_read_i, d_write_i, d_wdata_i,
        output d_rdata_o, d_resp_o,
        output m_addr_o, m_wdata_o, m_read_o, m_write_o,
        input  m_rdata_i, m_resp_i
    );

    modport master (
        output i_addr_i, i_read_i,
        input  i_rdata_o, i_resp_o,
        output d_addr_i, d_read_i, d_write_i, d_wdata_i,
        input  d_rdata_o, d_resp_o,
        input  m_addr_o, m_wdata_o, m_read_o, m_write_o,
        output m_rdata_i, m_resp_i
    );

endinterface

// File: rtl/cachebus_arbiter_pick.sv
// Combinational priority selector: data port first, instruction port once the data
// port has starved it for STARVE_LIMIT consecutive grants.
module cachebus_arb_pick
    import rvga_types::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             i_ireq,
    input  logic             i_dreq,
    input  logic [CNT_W-1:0] i_starve,
    output arb_gnt_e         o_gnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic w_starved;

    assign w_starved = i_ireq && (i_starve == LIMIT);

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_dreq && !w_starved) begin
            o_gnt = GNT_D;
        end else if (i_ireq) begin
            o_gnt = GNT_I;
        end
    end

endmodule

// File: rtl/cachebus_arbiter.sv
// Two-port (instruction/data) arbiter onto a single cachebus with one outstanding
// transaction, registered downstream strobes and starvation protection for fetches.
module cachebus_arbiter
    import rvga_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    cachebus_arbiter_if.slave  bus
);

    localparam int               CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_starve;
    logic [CNT_W-1:0] w_starve_nxt;
    rvga_word         r_addr;
    rvga_word         w_addr_nxt;
    rvga_word         r_wdata;
    rvga_word         w_wdata_nxt;
    logic             r_read;
    logic             w_read_nxt;
    logic             r_write;
    logic             w_write_nxt;
    logic             w_dreq;
    arb_gnt_e         w_gnt;

    assign w_dreq = bus.d_read_i | bus.d_write_i;

    cachebus_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_ireq   (bus.i_read_i),
        .i_dreq   (w_dreq),
        .i_starve (r_starve),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_starve <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_read   <= w_read_nxt;
            r_write  <= w_write_nxt;
        end
    end

    // Downstream fields only change on a grant from IDLE, so they stay frozen while busy.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_read_nxt   = r_read;
        w_write_nxt  = r_write;

        unique case (r_state)
            IDLE: begin
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                case (w_gnt)
                    GNT_D: begin
                        w_state_nxt = BUSY_D;
                        w_read_nxt  = bus.d_read_i & ~bus.d_write_i;
                        w_write_nxt = bus.d_write_i;
                        w_addr_nxt  = bus.d_addr_i;
                        w_wdata_nxt = bus.d_wdata_i;
                        if (bus.i_read_i && (r_starve != LIMIT)) begin
                            w_starve_nxt = r_starve + 1'b1;
                        end
                    end
                    GNT_I: begin
                        w_state_nxt  = BUSY_I;
                        w_read_nxt   = 1'b1;
                        w_addr_nxt   = bus.i_addr_i;
                        w_wdata_nxt  = '0;
                        w_starve_nxt = '0;
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
            BUSY_I, BUSY_D: begin
                if (bus.m_resp_i) begin
                    w_state_nxt = IDLE;
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
            end
        endcase
    end

    assign bus.m_addr_o  = r_addr;
    assign bus.m_wdata_o = r_wdata;
    assign bus.m_read_o  = r_read;
    assign bus.m_write_o = r_write;

    // Completion is routed to whichever port owns the bus; IDLE responses are dropped.
    assign bus.i_resp_o  = (r_state == BUSY_I) & bus.m_resp_i;
    assign bus.d_resp_o  = (r_state == BUSY_D) & bus.m_resp_i;
    assign bus.i_rdata_o = bus.m_rdata_i;
    assign bus.d_rdata_o = bus.m_rdata_i;

endmodule

// File: tb/tb_cachebus_arbiter.sv
// Scoreboard bench for cachebus_arbiter: a request-level model predicts each grant,
// a monitor checks grants, hold stability, bubbles and completions against it.
module tb_cachebus_arbiter;

    localparam int LIMIT = 4;

    typedef struct {
        int          port;   // 1 = instruction, 2 = data
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;

    cachebus_arbiter_if bus ();

    cachebus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    gnt_t exp_q[$];
    int   gnt_log[$];
    int   exp_seq[$];
    int   fixed_delay = -1;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_len"}, 32'(gnt_log.size()), 32'(exp_seq.size()));
        for (int k = 0; k < exp_seq.size() && k < gnt_log.size(); k++)
            chk(nm, 32'(gnt_log[k]), 32'(exp_seq[k]));
    endtask

    // Reference model: at each IDLE opportunity decide the grant from the port rules.
    initial begin
        bit busy;
        int cnt;
        busy = 0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                busy = 0;
                cnt  = 0;
                exp_q.delete();
            end else if (busy) begin
                if (bus.m_resp_i) busy = 0;
            end else begin
                gnt_t g;
                if ((bus.d_read_i || bus.d_write_i) && !(cnt == LIMIT && bus.i_read_i)) begin
                    g.port  = 2;
                    g.wr    = bus.d_write_i;
                    g.rd    = bus.d_read_i && !bus.d_write_i;
                    g.addr  = bus.d_addr_i;
                    g.wdata = bus.d_wdata_i;
                    exp_q.push_back(g);
                    if (bus.i_read_i && cnt < LIMIT) cnt++;
                    busy = 1;
                end else if (bus.i_read_i) begin
                    g.port  = 1;
                    g.rd    = 1'b1;
                    g.wr    = 1'b0;
                    g.addr  = bus.i_addr_i;
                    g.wdata = 32'h0;
                    exp_q.push_back(g);
                    cnt  = 0;
                    busy = 1;
                end
            end
        end
    end

    // Monitor: pops a prediction when a transaction appears downstream.
    initial begin
        gnt_t cur;
        bit   cur_act;
        bit   bubble;
        bit   act;
        bit   exp_i;
        bit   exp_d;
        cur_act = 0;
        bubble  = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                cur_act = 0;
                bubble  = 0;
            end else begin
                act = bus.m_read_o | bus.m_write_o;
                if (bubble) begin
                    chk("bubble_strobes", 32'(act), 32'h0);
                    bubble = 0;
                end else if (act && !cur_act) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 32'(act), 32'h0);
                    end else begin
                        cur     = exp_q.pop_front();
                        cur_act = 1;
                        gnt_log.push_back(cur.port);
                        chk("gnt_read",  32'(bus.m_read_o),  32'(cur.rd));
                        chk("gnt_write", 32'(bus.m_write_o), 32'(cur.wr));
                        chk("gnt_addr",  bus.m_addr_o,  cur.addr);
                        chk("gnt_wdata", bus.m_wdata_o, cur.wdata);
                    end
                end else if (act) begin
                    chk("hold_addr",  bus.m_addr_o,  cur.addr);
                    chk("hold_wdata", bus.m_wdata_o, cur.wdata);
                    chk("hold_strb",  32'({bus.m_read_o, bus.m_write_o}), 32'({cur.rd, cur.wr}));
                end else if (cur_act) begin
                    chk("busy_strobes_dropped", 32'(act), 32'h1);
                end

                if (bus.m_resp_i || bus.i_resp_o || bus.d_resp_o) begin
                    exp_i = cur_act && bus.m_resp_i && cur.port == 1;
                    exp_d = cur_act && bus.m_resp_i && cur.port == 2;
                    chk("i_resp", 32'(bus.i_resp_o), 32'(exp_i));
                    chk("d_resp", 32'(bus.d_resp_o), 32'(exp_d));
                    if (exp_i) chk("i_rdata", bus.i_rdata_o, rdata_for(cur.addr));
                    if (exp_d) chk("d_rdata", bus.d_rdata_o, rdata_for(cur.addr));
                    if (cur_act && bus.m_resp_i) begin
                        cur_act = 0;
                        bubble  = 1;
                    end
                end
            end
        end
    end

    // Downstream responder: completes each transaction after 0..3 extra cycles.
    initial begin
        int d;
        bus.m_resp_i  = 1'b0;
        bus.m_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.m_read_o || bus.m_write_o) begin
                d = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
                repeat (d) @(negedge clk);
                @(posedge clk);
                #1;
                bus.m_resp_i  = 1'b1;
                bus.m_rdata_i = rdata_for(bus.m_addr_o);
                @(posedge clk);
                #1;
                bus.m_resp_i  = 1'b0;
                bus.m_rdata_i = $urandom;
            end
        end
    end

    task automatic run_i(input logic [31:0] a);
        bit ok;
        ok = 0;
        bus.i_addr_i = a;
        bus.i_read_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.i_resp_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL i_resp_timeout: actual none required i_resp_o for %0h", a);
        end
        @(posedge clk);
        #1;
        bus.i_read_i = 1'b0;
    endtask

    task automatic run_d(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input bit perturb);
        bit ok;
        ok = 0;
        bus.d_addr_i  = a;
        bus.d_wdata_i = wd;
        bus.d_read_i  = rd;
        bus.d_write_i = wr;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.d_resp_o) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (perturb && $urandom_range(0, 2) == 0) begin
                bus.d_addr_i  = $urandom & 32'hFFFF_FFFC;
                bus.d_wdata_i = $urandom;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL d_resp_timeout: actual none required d_resp_o for %0h", a);
        end
        @(posedge clk);
        #1;
        bus.d_read_i  = 1'b0;
        bus.d_write_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_addr_i  = 32'h0;
        bus.i_read_i  = 1'b0;
        bus.d_addr_i  = 32'h0;
        bus.d_read_i  = 1'b0;
        bus.d_write_i = 1'b0;
        bus.d_wdata_i = 32'h0;

        // Reset state, checked before any clock edge.
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_m_read",  32'(bus.m_read_o),  32'h0);
        chk("rst_m_write", 32'(bus.m_write_o), 32'h0);
        chk("rst_m_addr",  bus.m_addr_o,  32'h0);
        chk("rst_m_wdata", bus.m_wdata_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Instruction-only fetch, response three cycles after the strobe.
        fixed_delay = 2;
        gnt_log.delete();
        run_i(32'h100);
        exp_seq = '{1};
        chk_log("ionly_seq");

        // Simultaneous requests: data write first, fetch after the bubble.
        fixed_delay = -1;
        gnt_log.delete();
        fork
            run_i(32'h104);
            run_d(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0);
        join
        exp_seq = '{2, 1};
        chk_log("simul_seq");

        // Address change during a data transaction must not reach the bus.
        fixed_delay = 3;
        fork
            run_d(1'b0, 1'b1, 32'h200, 32'h1234_5678, 1'b0);
            begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (bus.m_write_o) break;
                end
                @(posedge clk);
                #1 bus.d_addr_i = 32'h300;
                @(negedge clk);
                chk("hold_0x200_a", bus.m_addr_o, 32'h200);
                @(negedge clk);
                chk("hold_0x200_b", bus.m_addr_o, 32'h200);
            end
        join

        // Starvation: fetch held, data back-to-back.
        fixed_delay = -1;
        gnt_log.delete();
        fork
            begin
                run_i(32'h400);
                run_i(32'h404);
            end
            for (int n = 0; n < 8; n++)
                run_d(1'b1, 1'b0, 32'h800 + 32'(n * 4), 32'h0, 1'b0);
        join
        exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        chk_log("starve_seq");

        // Reset in the middle of a fetch; the late completion must be ignored.
        fixed_delay = 3;
        bus.i_addr_i = 32'h100;
        bus.i_read_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.m_read_o) break;
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("rstmid_m_read", 32'(bus.m_read_o), 32'h0);
        chk("rstmid_m_addr", bus.m_addr_o, 32'h0);
        bus.i_read_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        fixed_delay = -1;
        @(posedge clk);
        #1;

        // Randomized traffic on both ports.
        fork
            for (int n = 0; n < 40; n++) begin
                int gap;
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                end
                run_i($urandom & 32'hFFFF_FFFC);
            end
            for (int n = 0; n < 40; n++) begin
                int gap;
                int op;
                gap = $urandom_range(0, 3);
                op  = $urandom_range(0, 2);
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                end
                run_d(op != 1, op != 0, $urandom & 32'hFFFF_FFFC, $urandom, 1'b1);
            end
        join

        repeat (8) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cachebus_arbiter.md
CACHEBUS_ARBITER -- requirements
Module: cachebus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while the instruction port is pending.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 i_addr_i  input  32  instruction-port address (rvga_word).
REQ-005 i_read_i  input  1  instruction-port read request; held until i_resp_o.
REQ-006 i_rdata_o  output  32  instruction-port read data, valid with i_resp_o.
REQ-007 i_resp_o  output  1  instruction-port completion pulse.
REQ-008 d_addr_i  input  32  data-port address.
REQ-009 d_read_i  input  1  data-port read request; held until d_resp_o.
REQ-010 d_write_i  input  1  data-port write request; held until d_resp_o.
REQ-011 d_wdata_i  input  32  data-port write data.
REQ-012 d_rdata_o  output  32  data-port read data, valid with d_resp_o.
REQ-013 d_resp_o  output  1  data-port completion pulse.
REQ-014 m_addr_o, m_wdata_o  output  32  downstream cachebus address / write data.
REQ-015 m_read_o, m_write_o  output  1  downstream cachebus strobes.
REQ-016 m_rdata_i  input  32, m_resp_i  input  1  downstream read data and one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, BUSY_I, BUSY_D; IDLE after reset.
REQ-018 IDLE, no request pending: stay IDLE; all m_* strobes 0.
REQ-019 IDLE, grant evaluated combinationally; state, m_addr_o, m_wdata_o, m_read_o, m_write_o registered; downstream strobes first visible one cycle after request seen.
REQ-020 Priority: data port wins if d_read_i|d_write_i, unless starve count == STARVE_LIMIT and i_read_i, then instruction port wins.
REQ-021 Grant to instruction port: m_read_o=1, m_write_o=0, m_addr_o=i_addr_i, m_wdata_o=0; next state BUSY_I.
REQ-022 Grant to data port: m_read_o=d_read_i, m_write_o=d_write_i, m_addr_o=d_addr_i, m_wdata_o=d_wdata_i captured; next state BUSY_D.
REQ-023 d_read_i and d_write_i both 1: treated as write only (m_read_o=0).
REQ-024 BUSY_x: m_* outputs held constant regardless of requester input changes until m_resp_i.
REQ-025 m_resp_i in BUSY_I: i_resp_o=1 and i_rdata_o=m_rdata_i same cycle (combinational pass-through); d_resp_o=0.
REQ-026 m_resp_i in BUSY_D: d_resp_o=1, d_rdata_o=m_rdata_i same cycle; i_resp_o=0.
REQ-027 Cycle after m_resp_i: state IDLE, m_read_o=m_write_o=0 (one mandatory bubble before next grant).
REQ-028 m_resp_i in IDLE: ignored; no resp output asserted.
REQ-029 Starve counter, 3 bits min, width $clog2(STARVE_LIMIT+1): increments on data grant while i_read_i=1; clears on instruction grant; saturates at STARVE_LIMIT.
REQ-030 i_rdata_o, d_rdata_o driven with m_rdata_i continuously; meaningful only with own resp.

Reset
REQ-031 rst_ni low: state IDLE, starve counter 0, m_read_o=m_write_o=0, m_addr_o=m_wdata_o=0, immediately (asynchronous).
REQ-032 Reset mid-transaction abandons it; no resp output issued for it; late m_resp_i after reset ignored per REQ-028.
REQ-033 Release of rst_ni synchronous to clk_i; first grant possible on first edge after release.

Structure
REQ-034 State enum arb_state_e (IDLE, BUSY_I, BUSY_D) in shared package rvga_types; rvga_word reused for 32-bit ports.
REQ-035 One sub-module: cachebus_arb_pick, combinational priority/starvation selector (inputs: requests, starve count; output: grant select).

Verification
REQ-036 Instruction-only: i_read_i=1, addr 0x100, m_resp_i 3 cycles after m_read_o with rdata 0x00000013 -> m_addr_o=0x100, i_resp_o=1 with i_rdata_o=0x13, d_resp_o never 1.
REQ-037 Simultaneous: i_read_i and d_write_i (addr 0x200, wdata 0xDEADBEEF) same cycle -> data granted first with m_write_o=1, m_wdata_o=0xDEADBEEF; instruction granted after bubble.
REQ-038 Starvation: i_read_i held, data requests back-to-back, STARVE_LIMIT=4 -> exactly 4 data grants then instruction grant, counter back to 0.
REQ-039 Hold stability: change d_addr_i from 0x200 to 0x300 while BUSY_D -> m_addr_o stays 0x200 until m_resp_i.
REQ-040 Reset mid-op: rst_ni low during BUSY_I -> m_read_o=0 same cycle without edge; subsequent m_resp_i produces no i_resp_o.
